// File: rtl/remote_tx.sv
// Keyfob transmitter: debounces a raw push-button and, for each new press,
// sends one start/id/seq/parity/stop frame on a single idle-low wire.
module remote_tx #(
   parameter int unsigned BIT_CYCLES = 4,
   parameter int unsigned DEBOUNCE   = 3,
   parameter int unsigned GAP_BITS   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button,
   input  logic [7:0] id,
   output logic       tx,
   output logic       busy,
   output logic [1:0] seq,
   output logic       frame_done
);

   localparam int unsigned CYC_W   = $clog2(BIT_CYCLES);
   localparam int unsigned CNT_W   = $clog2(DEBOUNCE + 1);
   localparam int unsigned IDX_MAX = (GAP_BITS > 10) ? GAP_BITS : 10;
   localparam int unsigned IDX_W   = $clog2(IDX_MAX);

   localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
   localparam logic [CYC_W-1:0] CYC_PRE   = CYC_W'(BIT_CYCLES - 2);
   localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(9);
   localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_GAP
   } state_t;

   state_t           state;
   logic [1:0]       sync_q;
   logic [CNT_W-1:0] deb_cnt;
   logic             deb;
   logic             deb_q;
   logic             pending;
   logic [CYC_W-1:0] cyc;
   logic [IDX_W-1:0] idx;
   logic [9:0]       shreg;
   logic             par;

   logic btn_s_c;
   logic press_c;
   logic bit_end_c;
   logic gap_end_c;
   logic start_c;

   assign btn_s_c   = sync_q[1];
   assign press_c   = deb & ~deb_q;
   assign bit_end_c = (cyc == CYC_LAST);
   assign gap_end_c = (state == S_GAP) && bit_end_c && (idx == GAP_LAST);
   assign start_c   = ((state == S_IDLE) && press_c) ||
                      (gap_end_c && (pending || press_c));

   // Two-flop synchroniser on the asynchronous button.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], button};
   end

   // Saturating run-length counter; any low sample drops the level at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_cnt <= '0;
         deb     <= 1'b0;
         deb_q   <= 1'b0;
      end else begin
         deb_q <= deb;
         if (btn_s_c) begin
            if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + CNT_W'(1);
            if (32'(deb_cnt) + 32'd1 >= DEBOUNCE) deb <= 1'b1;
         end else begin
            deb_cnt <= '0;
            deb     <= 1'b0;
         end
      end
   end

   // Frame sequencer; tx is registered so it only moves on bit boundaries.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tx         <= 1'b0;
         busy       <= 1'b0;
         seq        <= 2'd0;
         frame_done <= 1'b0;
         pending    <= 1'b0;
         cyc        <= '0;
         idx        <= '0;
         shreg      <= '0;
         par        <= 1'b0;
      end else if (start_c) begin
         state      <= S_START;
         tx         <= 1'b1;
         busy       <= 1'b1;
         frame_done <= 1'b0;
         pending    <= 1'b0;
         cyc        <= '0;
         idx        <= '0;
         shreg      <= {id, seq};
         par        <= ^{id, seq};
      end else begin
         frame_done <= 1'b0;
         // One-deep queue of presses that arrive while a frame is in flight.
         if (press_c && busy && !pending) pending <= 1'b1;
         if (state == S_IDLE) cyc <= '0;
         else                 cyc <= bit_end_c ? '0 : cyc + CYC_W'(1);

         case (state)
            S_START: begin
               if (bit_end_c) begin
                  state <= S_DATA;
                  idx   <= '0;
                  tx    <= shreg[9];
                  shreg <= {shreg[8:0], 1'b0};
               end
            end
            S_DATA: begin
               if (bit_end_c) begin
                  if (idx == DATA_LAST) begin
                     state <= S_PARITY;
                     tx    <= par;
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     tx    <= shreg[9];
                     shreg <= {shreg[8:0], 1'b0};
                  end
               end
            end
            S_PARITY: begin
               if (bit_end_c) begin
                  state <= S_STOP;
                  tx    <= 1'b0;
               end
            end
            S_STOP: begin
               if (cyc == CYC_PRE) frame_done <= 1'b1;
               if (bit_end_c) begin
                  state <= S_GAP;
                  idx   <= '0;
                  seq   <= seq + 2'd1;
               end
            end
            S_GAP: begin
               if (bit_end_c) begin
                  if (idx == GAP_LAST) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_remote_tx.sv
// Directed bench for remote_tx: frame content, debounce, pending press,
// sequence wrap, mid-frame reset and long hold with id change.
module tb_remote_tx;

   localparam int BC        = 4;
   localparam int FRAME     = 13 * BC;
   localparam int BUSY_LEN  = FRAME + 2 * BC;

   logic       clk = 1'b0;
   logic       rst;
   logic       button;
   logic [7:0] id;
   logic       tx;
   logic       busy;
   logic [1:0] seq;
   logic       frame_done;

   int n_pass  = 0;
   int n_total = 0;

   logic [12:0] f_bits;
   bit          f_stable;
   int          f_done_cnt;
   int          f_done_pos;
   int          f_busy_ones;
   logic        f_busy_after;
   logic        f_tx_after;
   bit          w_ok;
   int          w_lat;

   remote_tx #(.BIT_CYCLES(4), .DEBOUNCE(3), .GAP_BITS(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .button     (button),
      .id         (id),
      .tx         (tx),
      .busy       (busy),
      .seq        (seq),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Press and wait for busy; lat counts edges from first driven-high cycle.
   task automatic wait_start(input int limit, input int hold);
      w_ok  = 1'b0;
      w_lat = -1;
      for (int i = 0; i < limit; i++) begin
         button = (i < hold);
         tick();
         if (busy === 1'b1) begin
            w_ok  = 1'b1;
            w_lat = i + 1;
            break;
         end
      end
   endtask

   // Called on the first START cycle; samples one frame plus its gap.
   task automatic get_frame(input logic [63:0] pat, input logic [7:0] id_mid);
      f_bits      = '0;
      f_stable    = 1'b1;
      f_done_cnt  = 0;
      f_done_pos  = -1;
      f_busy_ones = 0;
      for (int t = 0; t <= BUSY_LEN; t++) begin
         if (t == BUSY_LEN) begin
            f_busy_after = busy;
            f_tx_after   = tx;
         end else begin
            if (t < FRAME) begin
               if (t % BC == 0) f_bits[12 - t / BC] = tx;
               else if (tx !== f_bits[12 - t / BC]) f_stable = 1'b0;
            end else if (tx !== 1'b0) begin
               f_stable = 1'b0;
            end
            if (frame_done === 1'b1) begin
               f_done_cnt++;
               f_done_pos = t;
            end
            if (busy === 1'b1) f_busy_ones++;
            button = pat[t];
            if (t == 8) id = id_mid;
            tick();
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; button = 1'b0; id = 8'h00;
      tick(); tick();
      n_total++; if (tx !== 1'b0) $display("FAIL reset_tx got %b want 0", tx); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_total++; if (seq !== 2'd0) $display("FAIL reset_seq got %0d want 0", seq); else n_pass++;
      n_total++; if (frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", frame_done); else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      id = 8'hA5;
      wait_start(40, 10);
      n_total++; if (w_ok !== 1'b1 || w_lat !== 6) $display("FAIL basic_latency got ok=%0d lat=%0d want ok=1 lat=6", w_ok, w_lat); else n_pass++;
      get_frame(64'h0000_0000_0000_000F, 8'hA5);
      n_total++; if (f_bits !== 13'b1101001010000) $display("FAIL basic_bits got %b want %b", f_bits, 13'b1101001010000); else n_pass++;
      n_total++; if (f_stable !== 1'b1) $display("FAIL basic_stable got %0d want 1", f_stable); else n_pass++;
      n_total++; if (f_done_cnt !== 1 || f_done_pos !== 51) $display("FAIL basic_done got cnt=%0d pos=%0d want cnt=1 pos=51", f_done_cnt, f_done_pos); else n_pass++;
      n_total++; if (f_busy_ones !== 60) $display("FAIL basic_busy_len got %0d want 60", f_busy_ones); else n_pass++;
      n_total++; if (f_busy_after !== 1'b0) $display("FAIL basic_busy_after got %b want 0", f_busy_after); else n_pass++;
      n_total++; if (seq !== 2'd1) $display("FAIL basic_seq got %0d want 1", seq); else n_pass++;
   endtask

   task automatic test_bounce();
      logic [6:0] pat = 7'b1011011;
      bit bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         button = (i < 7) ? pat[i] : 1'b0;
         tick();
         if (tx !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      n_total++; if (bad !== 1'b0) $display("FAIL bounce_quiet got %0d want 0", bad); else n_pass++;
      wait_start(30, 3);
      n_total++; if (w_ok !== 1'b1 || w_lat !== 6) $display("FAIL bounce_latency got ok=%0d lat=%0d want ok=1 lat=6", w_ok, w_lat); else n_pass++;
      get_frame(64'h0, 8'hA5);
      n_total++; if (f_bits !== 13'b1101001010110) $display("FAIL bounce_bits got %b want %b", f_bits, 13'b1101001010110); else n_pass++;
      n_total++; if (f_done_cnt !== 1) $display("FAIL bounce_done got %0d want 1", f_done_cnt); else n_pass++;
      n_total++; if (seq !== 2'd2) $display("FAIL bounce_seq got %0d want 2", seq); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit bad = 1'b0;
      id = 8'h3C;
      wait_start(30, 3);
      n_total++; if (w_ok !== 1'b1) $display("FAIL b2b_start got %0d want 1", w_ok); else n_pass++;
      get_frame(64'h0000_0000_0E00_1C00, 8'h3C);
      n_total++; if (f_bits !== 13'b1001111001010) $display("FAIL b2b_bits1 got %b want %b", f_bits, 13'b1001111001010); else n_pass++;
      n_total++; if (f_busy_ones !== 60 || f_busy_after !== 1'b1) $display("FAIL b2b_busy1 got len=%0d after=%b want len=60 after=1", f_busy_ones, f_busy_after); else n_pass++;
      n_total++; if (f_tx_after !== 1'b1) $display("FAIL b2b_restart_tx got %b want 1", f_tx_after); else n_pass++;
      get_frame(64'h0, 8'h3C);
      n_total++; if (f_bits !== 13'b1001111001100) $display("FAIL b2b_bits2 got %b want %b", f_bits, 13'b1001111001100); else n_pass++;
      n_total++; if (f_done_cnt !== 1 || f_stable !== 1'b1) $display("FAIL b2b_done2 got cnt=%0d stable=%0d want cnt=1 stable=1", f_done_cnt, f_stable); else n_pass++;
      n_total++; if (f_busy_after !== 1'b0) $display("FAIL b2b_busy2_after got %b want 0", f_busy_after); else n_pass++;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (busy !== 1'b0) bad = 1'b1;
      end
      n_total++; if (bad !== 1'b0) $display("FAIL b2b_third_dropped got %0d want 0", bad); else n_pass++;
      n_total++; if (seq !== 2'd0) $display("FAIL b2b_seq got %0d want 0", seq); else n_pass++;
   endtask

   task automatic test_seq_wrap();
      logic [12:0] exp_bits [5];
      exp_bits[0] = 13'b1000000000000;
      exp_bits[1] = 13'b1000000000110;
      exp_bits[2] = 13'b1000000001010;
      exp_bits[3] = 13'b1000000001100;
      exp_bits[4] = 13'b1000000000000;
      id = 8'h00;
      for (int p = 0; p < 5; p++) begin
         wait_start(30, 3);
         get_frame(64'h0, 8'h00);
         n_total++; if (f_bits !== exp_bits[p]) $display("FAIL wrap_bits%0d got %b want %b", p, f_bits, exp_bits[p]); else n_pass++;
         n_total++; if (f_done_cnt !== 1) $display("FAIL wrap_done%0d got %0d want 1", p, f_done_cnt); else n_pass++;
         for (int i = 0; i < 5; i++) tick();
      end
      n_total++; if (seq !== 2'd1) $display("FAIL wrap_seq got %0d want 1", seq); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit bad = 1'b0;
      id = 8'h5A;
      wait_start(30, 3);
      for (int t = 0; t < 21; t++) tick();
      rst = 1'b1;
      tick();
      n_total++; if (tx !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_line got tx=%b busy=%b want tx=0 busy=0", tx, busy); else n_pass++;
      n_total++; if (seq !== 2'd0) $display("FAIL rstmid_seq got %0d want 0", seq); else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (frame_done !== 1'b0 || busy !== 1'b0 || tx !== 1'b0) bad = 1'b1;
         tick();
      end
      n_total++; if (bad !== 1'b0) $display("FAIL rstmid_no_done got %0d want 0", bad); else n_pass++;
      wait_start(30, 3);
      get_frame(64'h0, 8'h5A);
      n_total++; if (f_bits !== 13'b1010110100000) $display("FAIL rstmid_bits got %b want %b", f_bits, 13'b1010110100000); else n_pass++;
      n_total++; if (seq !== 2'd1) $display("FAIL rstmid_seq_after got %0d want 1", seq); else n_pass++;
   endtask

   task automatic test_hold_id_change();
      bit bad = 1'b0;
      id = 8'hC3;
      wait_start(30, 1000);
      n_total++; if (w_ok !== 1'b1 || w_lat !== 6) $display("FAIL hold_latency got ok=%0d lat=%0d want ok=1 lat=6", w_ok, w_lat); else n_pass++;
      get_frame(64'hFFFF_FFFF_FFFF_FFFF, 8'h24);
      n_total++; if (f_bits !== 13'b1110000110110) $display("FAIL hold_bits got %b want %b", f_bits, 13'b1110000110110); else n_pass++;
      n_total++; if (f_done_cnt !== 1 || f_busy_after !== 1'b0) $display("FAIL hold_done got cnt=%0d busy=%b want cnt=1 busy=0", f_done_cnt, f_busy_after); else n_pass++;
      for (int i = 0; i < 154; i++) begin
         button = (i < 134);
         tick();
         if (busy !== 1'b0) bad = 1'b1;
      end
      n_total++; if (bad !== 1'b0) $display("FAIL hold_no_retrigger got %0d want 0", bad); else n_pass++;
      n_total++; if (seq !== 2'd2) $display("FAIL hold_seq got %0d want 2", seq); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bounce();
      test_back_to_back();
      test_seq_wrap();
      test_reset_mid();
      test_hold_id_change();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_total);
      $fatal(1);
   end

endmodule

// File: doc/remote_tx.md
Name: remote_tx

Overview:
- Keyfob-side transmitter for the alarm's `remote` input. It debounces a raw push-button and, on each new press, serialises one coded frame onto a single wire: start bit, 8-bit fob ID, 2-bit rolling sequence, even parity, stop bit.
- It sits in the remote unit. Its `tx` output drives the alarm controller's `remote` line through the link model in system benches.

Parameters:
- BIT_CYCLES, 4: clock cycles per transmitted bit. Legal range is 2 or more.
- DEBOUNCE, 3: consecutive high samples of `button` needed to accept a press. Legal range is 1 or more.
- GAP_BITS, 2: bit periods of forced idle (`tx`=0) after each frame, before the next frame may start.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- button  in  1  raw push-button level, asynchronous to the design. It is double-flopped inside the block before debounce; this sync delay is included in the latency figures below.
- id  in  8  fob identity; sampled only when a frame starts.
- tx  out  1  serial line; idles at 0.
- busy  out  1  high from frame start through the end of the gap period.
- seq  out  2  sequence value to be used by the next frame.
- frame_done  out  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset: rst=1 at a clock edge gives tx=0, busy=0, seq=0, frame_done=0. The FSM goes to IDLE; the debounce counter, debounced level and pending flag are all cleared.
- Reset mid-frame aborts the frame: tx=0 from that edge, and no frame_done is issued.
- Synchroniser: 2 flops on `button`. The debouncer sees the synchronised signal.
- Debounce:
  - A counter counts consecutive synchronised-high samples and saturates at DEBOUNCE.
  - The debounced level goes to 1 when the count reaches DEBOUNCE.
  - Any low sample clears the counter and the debounced level on the same edge.
  - A press event is the 0->1 transition of the debounced level. Holding the button never retriggers.
- FSM states and transitions:
  - IDLE: on a press event, go to START next edge.
  - START → DATA → PARITY → STOP → GAP.
  - GAP → IDLE. If pending=1, go straight to START instead, and clear pending.
- Bit timing: every bit state lasts exactly BIT_CYCLES cycles. GAP lasts GAP_BITS*BIT_CYCLES cycles with tx=0.
- Frame content, registered so tx changes only on bit boundaries:
  - START: 1.
  - DATA: id[7] down to id[0], then seq[1], then seq[0] (10 bits).
  - PARITY: XOR of the 8 id bits and the 2 seq bits, which makes the total count of ones over id+seq+parity even.
  - STOP: 0.
  - Frame length is 13*BIT_CYCLES cycles.
- id and seq are captured into the shift register on the IDLE/GAP→START edge. Later changes to `id` do not affect the frame in flight.
- busy: 1 on the same edge tx enters START, held through GAP, and 0 on return to IDLE.
- frame_done: high during the final cycle of STOP.
- seq: increments by 1, mod 4 (3→0 wraps), on the edge following frame_done. The next frame therefore carries the new value.
- Latency: first synchronised-high sample at edge k gives tx=1 at edge k+DEBOUNCE.
- Press during busy:
  - The pending flag is set (one deep); further presses while pending=1 are dropped.
  - The pending frame starts on the first cycle after GAP, with no IDLE cycle in between.
- Press event and reset on the same edge: reset wins and no frame is sent.
- Button released mid-frame: no effect on the frame.

Test Plan:
- Basic frame: id=8'hA5, seq=0, press held 10 cycles. tx per bit = 1,1,0,1,0,0,1,0,1,0,0,0,0, each 4 cycles. busy stays high for 52+8=60 cycles. One frame_done pulse. seq becomes 1 afterwards.
- Bounce rejection: button pattern 1,1,0,1,1,0,1 (cycle by cycle), then low. tx must stay 0 and busy must stay 0 throughout. Then a clean 3-cycle press gives tx=1 exactly DEBOUNCE edges after its first synchronised-high sample.
- Pending press: a second press during the DATA state. The second frame's START begins on the cycle after GAP ends, with seq=1 in its payload (bits 0,1) and parity recomputed. A third press in the same frame is dropped, so only 2 frames are sent in total.
- Sequence wrap: 5 separated presses with id=8'h00. Payload seq = 0,1,2,3,0; parity = 0,1,1,0,0; final seq output = 1.
- Reset mid-frame: assert rst for 1 cycle during DATA bit 4. tx=0, busy=0, seq=0 from that edge, and no frame_done is issued. A new press afterwards sends a full frame with seq=0.
- Hold and id change: hold the button for 200 cycles while changing id during the frame. Exactly one frame is sent, and it carries the id captured at START.
